// File: rtl/bcd_seg_pkg.sv
// rtl/bcd_seg_pkg.sv - segment codes, segment typedef and BCD decode function
package bcd_seg_pkg;

    typedef logic [6:0] bcd_seg_t;

    // active-low {a,b,c,d,e,f,g}
    localparam bcd_seg_t SEG_0    = 7'b0000001;
    localparam bcd_seg_t SEG_1    = 7'b1001111;
    localparam bcd_seg_t SEG_2    = 7'b0010010;
    localparam bcd_seg_t SEG_3    = 7'b0000110;
    localparam bcd_seg_t SEG_4    = 7'b1001100;
    localparam bcd_seg_t SEG_5    = 7'b0100100;
    localparam bcd_seg_t SEG_6    = 7'b0100000;
    localparam bcd_seg_t SEG_7    = 7'b0001111;
    localparam bcd_seg_t SEG_8    = 7'b0000000;
    localparam bcd_seg_t SEG_9    = 7'b0000100;
    localparam bcd_seg_t SEG_DASH = 7'b1111110;
    localparam bcd_seg_t SEG_OFF  = 7'b1111111;

    function automatic bcd_seg_t bcd_to_seg_f(input logic [3:0] digit);
        bcd_seg_t seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_seg_scan_driver_bcd_to_seg.sv
// rtl/bcd_seg_scan_driver_bcd_to_seg.sv - combinational BCD digit to active-low 7-segment decoder
module bcd_to_seg
    import bcd_seg_pkg::*;
(
    input  logic [3:0] digit,
    output bcd_seg_t   seg
);

    assign seg = bcd_to_seg_f(digit);

endmodule

// File: rtl/bcd_seg_scan_driver.sv
// rtl/bcd_seg_scan_driver.sv - sync/debounce of async BCD bus and multiplexed 7-segment scan driver
// Optional leading-zero blanking is enabled with macro LEADING_ZERO_BLANK_EN.
module bcd_seg_scan_driver
    import bcd_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV      = 1000,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk1,
    input  logic                    r,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    err
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [W-1:0]  s1, s2, prev, disp;
    logic [CW-1:0] stab_cnt;
    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic          first_slot;

    logic          commit;
    logic          s2_invalid;
    logic          terminal;
    logic          blank_slot;
    logic          digit_off;
    logic [3:0]    cur_digit;
    bcd_seg_t      dec_seg;

    assign terminal   = (presc == PW'(SCAN_DIV - 1));
    // The very first slot after reset is not blanked so a digit appears on the first edge.
    assign blank_slot = (presc == '0) && !first_slot;
    assign commit     = (s2 == prev) && (stab_cnt == CW'(STABLE_CYCLES - 1));

    always_comb begin
        s2_invalid = 1'b0;
        cur_digit  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (s2[4*i +: 4] > 4'd9) s2_invalid = 1'b1;
            if (IW'(i) == idx) cur_digit = disp[4*i +: 4];
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero;

    // lead_zero[i]: digit i and every digit above it are zero
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        lead_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (disp[4*i +: 4] == 4'd0);
            lead_zero[i] = zero_run;
        end
        digit_off = 1'b0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (IW'(i) == idx) digit_off = lead_zero[i];
        end
    end
`else
    assign digit_off = 1'b0;
`endif

    bcd_to_seg u_dec (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

    always_ff @(posedge clk1 or negedge r) begin
        if (!r) begin
            s1       <= '0;
            s2       <= '0;
            prev     <= '0;
            stab_cnt <= '0;
            disp     <= '0;
            err      <= 1'b0;
        end else begin
            s1   <= bcd_in;
            s2   <= s1;
            prev <= s2;
            if (s2 == prev) begin
                if (stab_cnt != CW'(STABLE_CYCLES - 1)) stab_cnt <= stab_cnt + 1'b1;
            end else begin
                stab_cnt <= '0;
            end
            if (commit) begin
                disp <= s2;
                if (s2_invalid) err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk1 or negedge r) begin
        if (!r) begin
            presc      <= '0;
            idx        <= '0;
            first_slot <= 1'b1;
        end else if (terminal) begin
            presc      <= '0;
            first_slot <= 1'b0;
            idx        <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk1 or negedge r) begin
        if (!r) begin
            seg_n <= SEG_OFF;
            an_n  <= '1;
        end else begin
            seg_n <= digit_off ? SEG_OFF : dec_seg;
            an_n  <= blank_slot ? '1 : ~(NUM_DIGITS'(1) << idx);
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan_driver.sv
// tb/tb_bcd_seg_scan_driver.sv - randomized self-checking bench for bcd_seg_scan_driver
module tb_bcd_seg_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int SC = 3;

    logic        clk1 = 1'b0;
    logic        r;
    logic [15:0] bcd_in;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk1 = ~clk1;

    bcd_seg_scan_driver #(
        .NUM_DIGITS    (ND),
        .SCAN_DIV      (SD),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk1   (clk1),
        .r      (r),
        .bcd_in (bcd_in),
        .seg_n  (seg_n),
        .an_n   (an_n),
        .err    (err)
    );

    // reference model: edge count since reset, sampled-input history, committed value
    int          cyc;
    logic [15:0] m_s1, m_disp;
    logic [15:0] hist[$];
    logic        m_err;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_err;

    function automatic logic [6:0] dec(input logic [3:0] d);
        logic [6:0] tbl [0:9];
        tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        if (d > 4'd9) return 7'b1111110;
        return tbl[d];
    endfunction

    function automatic logic [6:0] ref_seg(input logic [15:0] disp, input int i);
        logic [3:0] d;
        d = disp[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && (disp >> (4*i)) == 16'd0) return 7'h7F;
`endif
        return dec(d);
    endfunction

    function automatic logic [15:0] rand_valid();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic model_reset();
        cyc     = 0;
        m_s1    = '0;
        m_disp  = '0;
        m_err   = 1'b0;
        hist    = {16'h0, 16'h0};
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_err = 1'b0;
    endtask

    task automatic step(input logic [15:0] v);
        int  slot, pos, idx;
        bit  stable;
        bcd_in = v;
        @(posedge clk1);
        slot    = cyc / SD;
        pos     = cyc % SD;
        idx     = slot % ND;
        exp_an  = (pos == 0 && slot > 0) ? 4'hF : ~(4'b0001 << idx);
        exp_seg = ref_seg(m_disp, idx);
        stable  = (hist.size() >= SC + 1);
        for (int k = 0; k <= SC && stable; k++)
            if (hist[hist.size() - 1 - k] != hist[hist.size() - 1]) stable = 0;
        if (stable) begin
            m_disp = hist[hist.size() - 1];
            for (int i = 0; i < 4; i++) if (m_disp[4*i +: 4] > 4'd9) m_err = 1'b1;
        end
        exp_err = m_err;
        hist.push_back(m_s1);
        m_s1 = v;
        if (hist.size() > SC + 1) void'(hist.pop_front());
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        r = 1'b0;
        bcd_in = 16'h1234;
        model_reset();
        repeat (3) @(posedge clk1);
        #1;
        total++;
        if (seg_n !== 7'h7F || an_n !== 4'hF || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_values seg=%b an=%h err=%b want seg=1111111 an=f err=0", seg_n, an_n, err);
        end
        @(negedge clk1);
        r = 1'b1;
        step(16'h1234);
        total++;
        if (an_n !== 4'hE || seg_n !== 7'b0000001) begin
            bad++;
            $display("FAIL first_edge an=%h seg=%b want an=e seg=0000001", an_n, seg_n);
        end
        for (int n = 0; n < 10; n++) begin
            step(16'h1234);
            total++;
            if (an_n !== exp_an || seg_n !== exp_seg || err !== exp_err) begin
                bad++;
                $display("FAIL reset_settle cyc=%0d an=%h/%h seg=%b/%b err=%b/%b", cyc, an_n, exp_an, seg_n, exp_seg, err, exp_err);
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0] last_an;
        int         slots_seen;
        last_an    = an_n;
        slots_seen = 0;
        for (int n = 0; n < 40; n++) begin
            step(16'h1234);
            total++;
            if (an_n !== exp_an || seg_n !== exp_seg) begin
                bad++;
                $display("FAIL scan cyc=%0d an=%h/%h seg=%b/%b", cyc, an_n, exp_an, seg_n, exp_seg);
            end
            if (an_n != last_an && an_n != 4'hF) slots_seen++;
            if (an_n != 4'hF) last_an = an_n;
        end
        total++;
        if (slots_seen != 10) begin
            bad++;
            $display("FAIL scan_slot_count got=%0d want=10", slots_seen);
        end
    endtask

    task automatic test_glitch();
        logic [15:0] seq [0:23];
        for (int n = 0; n < 24; n++)
            seq[n] = (n < 10) ? 16'h1239 : (n < 12) ? 16'h123A : 16'h1230;
        for (int n = 0; n < 24; n++) begin
            step(seq[n]);
            total++;
            if (an_n !== exp_an || seg_n !== exp_seg || err !== 1'b0 || seg_n === 7'b1111110) begin
                bad++;
                $display("FAIL glitch cyc=%0d an=%h/%h seg=%b/%b err=%b/0", cyc, an_n, exp_an, seg_n, exp_seg, err);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        int          hold;
        for (int seg_i = 0; seg_i < 60; seg_i++) begin
            if ($urandom_range(0, 7) == 0) begin
                v = rand_valid();
                v[3:0] = 4'($urandom_range(10, 15));
                hold = $urandom_range(1, 3);
            end else begin
                v = rand_valid();
                hold = $urandom_range(1, 10);
            end
            for (int h = 0; h < hold; h++) begin
                step(v);
                total++;
                if (an_n !== exp_an || seg_n !== exp_seg || err !== exp_err) begin
                    bad++;
                    $display("FAIL random cyc=%0d in=%h an=%h/%h seg=%b/%b err=%b/%b", cyc, v, an_n, exp_an, seg_n, exp_seg, err, exp_err);
                end
            end
        end
    endtask

    task automatic test_invalid();
        int dash_seen;
        dash_seen = 0;
        for (int n = 0; n < 28; n++) begin
            step(16'h12A4);
            total++;
            if (an_n !== exp_an || seg_n !== exp_seg || err !== exp_err) begin
                bad++;
                $display("FAIL invalid cyc=%0d an=%h/%h seg=%b/%b err=%b/%b", cyc, an_n, exp_an, seg_n, exp_seg, err, exp_err);
            end
            if (n >= 10 && an_n == 4'b1101) begin
                total++;
                dash_seen++;
                if (seg_n !== 7'b1111110) begin
                    bad++;
                    $display("FAIL invalid_dash seg=%b want=1111110", seg_n);
                end
            end
        end
        total++;
        if (err !== 1'b1 || dash_seen == 0) begin
            bad++;
            $display("FAIL invalid_err err=%b dash_slots=%0d want err=1 dash_slots>0", err, dash_seen);
        end
        for (int n = 0; n < 20; n++) step(16'h1234);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky err=%b want=1", err);
        end
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 3 * SD && (cyc % SD) != 2; n++) step(16'h5678);
        #1 r = 1'b0;
        #1;
        total++;
        if (seg_n !== 7'h7F || an_n !== 4'hF || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid seg=%b an=%h err=%b want seg=1111111 an=f err=0", seg_n, an_n, err);
        end
        model_reset();
        #3 r = 1'b1;
        step(16'h5678);
        total++;
        if (an_n !== 4'hE || seg_n !== 7'b0000001) begin
            bad++;
            $display("FAIL reset_mid_restart an=%h seg=%b want an=e seg=0000001", an_n, seg_n);
        end
        for (int n = 0; n < 16; n++) begin
            step(16'h5678);
            total++;
            if (an_n !== exp_an || seg_n !== exp_seg || err !== exp_err) begin
                bad++;
                $display("FAIL reset_mid_scan cyc=%0d an=%h/%h seg=%b/%b", cyc, an_n, exp_an, seg_n, exp_seg);
            end
        end
    endtask

    task automatic test_lzb();
        logic [6:0] want;
`ifdef LEADING_ZERO_BLANK_EN
        logic [6:0] hi_want = 7'h7F;
`else
        logic [6:0] hi_want = 7'b0000001;
`endif
        for (int n = 0; n < 48; n++) begin
            step(16'h0070);
            total++;
            if (an_n !== exp_an || seg_n !== exp_seg) begin
                bad++;
                $display("FAIL lzb_model cyc=%0d an=%h/%h seg=%b/%b", cyc, an_n, exp_an, seg_n, exp_seg);
            end
            if (n >= 12 && an_n != 4'hF) begin
                case (an_n)
                    4'b1110: want = 7'b0000001;
                    4'b1101: want = 7'b0001111;
                    default: want = hi_want;
                endcase
                total++;
                if (seg_n !== want) begin
                    bad++;
                    $display("FAIL lzb_slot an=%h seg=%b want=%b", an_n, seg_n, want);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_glitch();
        test_random();
        test_invalid();
        test_reset_mid();
        test_lzb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
